// File: rtl/alu_result_queue.sv
// alu_result_queue: small FIFO that buffers alu64 results (Y, opcode, flags)
// and evaluates a branch-style condition on the head entry.
//
// Handshake rule (both ports): a transfer happens on a rising clk edge when
// valid && ready are both high. in_ready and out_valid come purely from
// registered occupancy, so neither depends combinationally on the other side.
//
// Optional feature: define ALU_RESULT_QUEUE_STICKY_EN to build the sticky
// {CF,OF} accumulator. Without it, sticky reads 2'b00 and sticky_clr is unused.
module alu_result_queue #(
    parameter int DEPTH = 4,
    parameter int W     = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [W-1:0]             in_y,
    input  logic [3:0]               in_op,
    input  logic [3:0]               in_flags,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_y,
    output logic [3:0]               out_op,
    output logic [3:0]               out_flags,
    input  logic [2:0]               cond_sel,
    output logic                     cond_true,
    output logic [$clog2(DEPTH):0]   count,
    input  logic                     sticky_clr,
    output logic [1:0]               sticky
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // Storage is deliberately not reset; out_valid gates its visibility.
    logic [W-1:0] mem_y     [DEPTH];
    logic [3:0]   mem_op    [DEPTH];
    logic [3:0]   mem_flags [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count_q;

    logic push;
    logic pop;

    // Flag bit positions inside {ZF,SF,CF,OF}
    logic zf;
    logic sf;
    logic cf;
    logic of_bit;

    assign in_ready  = (count_q < FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    // A full queue never admits a push, even if it pops in the same cycle.
    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    assign out_y     = mem_y[rd_ptr];
    assign out_op    = mem_op[rd_ptr];
    assign out_flags = mem_flags[rd_ptr];

    assign zf     = out_flags[3];
    assign sf     = out_flags[2];
    assign cf     = out_flags[1];
    assign of_bit = out_flags[0];

    // Write the payload into the slot at the write pointer on an accepted push.
    always_ff @(posedge clk) begin
        if (push && !rst) begin
            mem_y[wr_ptr]     <= in_y;
            mem_op[wr_ptr]    <= in_op;
            mem_flags[wr_ptr] <= in_flags;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Condition on the head entry; forced low when the queue is empty.
    always_comb begin
        cond_true = 1'b0;
        if (out_valid) begin
            case (cond_sel)
                3'd0:    cond_true = zf;
                3'd1:    cond_true = !zf;
                3'd2:    cond_true = sf ^ of_bit;
                3'd3:    cond_true = !(sf ^ of_bit);
                3'd4:    cond_true = cf;
                3'd5:    cond_true = !cf;
                3'd6:    cond_true = sf;
                default: cond_true = 1'b1;
            endcase
        end
    end

`ifdef ALU_RESULT_QUEUE_STICKY_EN
    logic [1:0] sticky_q;

    // Accumulate CF/OF of popped entries; a set in the same cycle wins over clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_q <= 2'b00;
        end else begin
            if (pop && cf) begin
                sticky_q[1] <= 1'b1;
            end else if (sticky_clr) begin
                sticky_q[1] <= 1'b0;
            end
            if (pop && of_bit) begin
                sticky_q[0] <= 1'b1;
            end else if (sticky_clr) begin
                sticky_q[0] <= 1'b0;
            end
        end
    end

    assign sticky = sticky_q;
`else
    logic sticky_clr_unused;

    assign sticky_clr_unused = sticky_clr;
    assign sticky            = 2'b00;
`endif

endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based model of the result buffer.
// Honours ALU_RESULT_QUEUE_STICKY_EN the same way the design does.
module tb_alu_result_queue;

    localparam int DEPTH = 4;
    localparam int W     = 64;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  in_y = '0;
    logic [3:0]    in_op = '0;
    logic [3:0]    in_flags = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_y;
    logic [3:0]    out_op;
    logic [3:0]    out_flags;
    logic [2:0]    cond_sel = '0;
    logic          cond_true;
    logic [CW-1:0] count;
    logic          sticky_clr = 1'b0;
    logic [1:0]    sticky;

    int total = 0;
    int bad   = 0;

    // Model state: entries are {flags, op, y}, oldest at the front.
    logic [W+7:0] exp_q[$];
    logic [1:0]   exp_sticky = 2'b00;
    bit           model_live = 1'b0;

`ifdef ALU_RESULT_QUEUE_STICKY_EN
    localparam bit STICKY_ON = 1'b1;
`else
    localparam bit STICKY_ON = 1'b0;
`endif

    alu_result_queue #(.DEPTH(DEPTH), .W(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_y       (in_y),
        .in_op      (in_op),
        .in_flags   (in_flags),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_y      (out_y),
        .out_op     (out_op),
        .out_flags  (out_flags),
        .cond_sel   (cond_sel),
        .cond_true  (cond_true),
        .count      (count),
        .sticky_clr (sticky_clr),
        .sticky     (sticky)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Condition rules written directly from the flag names.
    function automatic logic cond_of(input logic [3:0] fl, input logic [2:0] sel);
        logic zf, sf, cf, ovf;
        {zf, sf, cf, ovf} = fl;
        case (sel)
            3'd0: return zf;
            3'd1: return !zf;
            3'd2: return sf != ovf;
            3'd3: return sf == ovf;
            3'd4: return cf;
            3'd5: return !cf;
            3'd6: return sf;
            default: return 1'b1;
        endcase
    endfunction

    // Compare DUT with the model mid-cycle, then advance the model across the next edge.
    initial begin
        logic [W+7:0] head;
        int           sz;
        bit           do_push, do_pop;
        forever begin
            @(negedge clk);
            if (model_live) begin
                sz = exp_q.size();
                chk("count", 64'(count), 64'(sz));
                chk("in_ready", 64'(in_ready), 64'(sz < DEPTH));
                chk("out_valid", 64'(out_valid), 64'(sz != 0));
                chk("sticky", 64'(sticky), 64'(exp_sticky));
                if (sz != 0) begin
                    head = exp_q[0];
                    chk("out_y", out_y, head[W-1:0]);
                    chk("out_op", 64'(out_op), 64'(head[W+3:W]));
                    chk("out_flags", 64'(out_flags), 64'(head[W+7:W+4]));
                    chk("cond_true", 64'(cond_true), 64'(cond_of(head[W+7:W+4], cond_sel)));
                end else begin
                    chk("cond_true_empty", 64'(cond_true), 64'd0);
                end
            end
            if (rst) begin
                exp_q.delete();
                exp_sticky = 2'b00;
                model_live = 1'b1;
            end else if (model_live) begin
                sz      = exp_q.size();
                do_push = in_valid && (sz < DEPTH);
                do_pop  = out_ready && (sz != 0);
                if (STICKY_ON && sticky_clr) exp_sticky = 2'b00;
                if (do_pop) begin
                    head = exp_q.pop_front();
                    if (STICKY_ON && head[W+5]) exp_sticky[1] = 1'b1;
                    if (STICKY_ON && head[W+4]) exp_sticky[0] = 1'b1;
                end
                if (do_push) exp_q.push_back({in_flags, in_op, in_y});
            end
        end
    end

    // Driver tasks
    task automatic drive(input logic v, input logic [W-1:0] y, input logic [3:0] op,
                         input logic [3:0] fl, input logic rdy, input logic clr);
        in_valid   = v;
        in_y       = y;
        in_op      = op;
        in_flags   = fl;
        out_ready  = rdy;
        sticky_clr = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, '0, 4'h0, 4'h0, 1'b0, 1'b0);
    endtask

    initial begin
        // Reset
        rst = 1'b1;
        idle();
        tick();
        tick();
        rst = 1'b0;
        chk("reset_count", 64'(count), 64'd0);
        chk("reset_in_ready", 64'(in_ready), 64'd1);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sticky", 64'(sticky), 64'd0);

        // Single result 10+5 = 15, NE condition
        cond_sel = 3'd1;
        drive(1'b1, 64'd15, 4'b0000, 4'b0000, 1'b0, 1'b0);
        chk("no_same_cycle_visibility", 64'(out_valid), 64'd0);
        tick();
        idle();
        chk("single_out_valid", 64'(out_valid), 64'd1);
        chk("single_out_y", out_y, 64'd15);
        chk("single_count", 64'(count), 64'd1);
        chk("single_cond_ne", 64'(cond_true), 64'd1);
        drive(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0);
        tick();
        idle();
        chk("single_drained", 64'(count), 64'd0);

        // Fill to capacity, try a fifth push, then drain in order
        for (int k = 1; k <= 4; k++) begin
            drive(1'b1, 64'(k), 4'h2, 4'h0, 1'b0, 1'b0);
            tick();
        end
        drive(1'b1, 64'd5, 4'h2, 4'h0, 1'b0, 1'b0);
        tick();
        chk("full_count", 64'(count), 64'd4);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        drive(1'b1, 64'd6, 4'h2, 4'h0, 1'b1, 1'b0);
        tick();
        chk("full_pop_no_push", 64'(count), 64'd3);
        drive(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0);
        for (int k = 2; k <= 4; k++) begin
            chk("drain_order", out_y, 64'(k));
            tick();
        end
        idle();
        chk("drain_empty", 64'(count), 64'd0);

        // Steady stream: one push and one pop every cycle
        drive(1'b1, 64'd0, 4'h1, 4'h0, 1'b1, 1'b0);
        tick();
        for (int k = 1; k <= 9; k++) begin
            chk("stream_count", 64'(count), 64'd1);
            chk("stream_out_y", out_y, 64'(k - 1));
            drive(1'b1, 64'(k), 4'h1, 4'h0, 1'b1, 1'b0);
            tick();
        end
        chk("stream_last", out_y, 64'd9);
        drive(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0);
        tick();
        idle();

        // Signed-less-than on SF=1, OF=0; empty queue forces cond_true low
        cond_sel = 3'd2;
        drive(1'b1, 64'hDEAD, 4'h3, 4'b0100, 1'b0, 1'b0);
        tick();
        idle();
        chk("cond_lt", 64'(cond_true), 64'd1);
        cond_sel = 3'd3;
        #1;
        chk("cond_ge", 64'(cond_true), 64'd0);
        drive(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0);
        tick();
        idle();
        cond_sel = 3'd7;
        #1;
        chk("cond_empty_always", 64'(cond_true), 64'd0);

        // Sticky accumulation, then clear racing an OF pop
        drive(1'b1, 64'h7, 4'h0, 4'b0011, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b0);
        tick();
        idle();
        chk("sticky_set", 64'(sticky), STICKY_ON ? 64'd3 : 64'd0);
        drive(1'b1, 64'h8, 4'h0, 4'b0001, 1'b0, 1'b0);
        tick();
        drive(1'b0, '0, 4'h0, 4'h0, 1'b1, 1'b1);
        tick();
        idle();
        chk("sticky_set_beats_clr", 64'(sticky), STICKY_ON ? 64'd1 : 64'd0);

        // Reset with three entries queued and handshakes active
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 64'(k + 100), 4'h0, 4'b0011, 1'b0, 1'b0);
            tick();
        end
        chk("pre_reset_count", 64'(count), 64'd3);
        drive(1'b1, 64'h55, 4'h0, 4'b0011, 1'b1, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        idle();
        chk("midreset_count", 64'(count), 64'd0);
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_in_ready", 64'(in_ready), 64'd1);
        chk("midreset_sticky", 64'(sticky), 64'd0);

        // Randomized traffic with occasional resets and clears
        for (int c = 0; c < 3000; c++) begin
            drive(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom_range(0, 15)),
                  4'($urandom_range(0, 15)), 1'($urandom_range(0, 2) != 0),
                  1'($urandom_range(0, 9) == 0));
            cond_sel = 3'($urandom_range(0, 7));
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
